// File: rtl/conv_window_controller.sv
// Raster-order window sequencer for the convolver shift-register chain.
// Gates each shift with valid/ready and flags cycles where a full KxK window is resident.
module conv_window_controller #(
  parameter int IMAGE_WIDTH  = 8,
  parameter int IMAGE_HEIGHT = 8,
  parameter int KERNEL_SIZE  = 3,
  parameter int DATA_WIDTH   = 32,
  localparam int RW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1,
  localparam int CW = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  shift_enable,
  output logic [DATA_WIDTH-1:0] shift_data,
  output logic                  window_valid,
  output logic [RW-1:0]         win_row,
  output logic [CW-1:0]         win_col,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [RW-1:0] ROW_LAST = RW'(IMAGE_HEIGHT - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(IMAGE_WIDTH - 1);
  localparam logic [RW-1:0] ROW_K    = RW'(KERNEL_SIZE - 1);
  localparam logic [CW-1:0] COL_K    = CW'(KERNEL_SIZE - 1);

  state_t        state;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic          accept;

  assign in_ready     = (state == RUN);
  assign busy         = (state == RUN);
  assign accept       = in_valid & in_ready;
  assign shift_enable = accept;
  assign shift_data   = in_data;

  // The window flag lands on the same edge the shift register absorbs the pixel,
  // so window_valid lines up with the chain's updated contents.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      row          <= '0;
      col          <= '0;
      window_valid <= 1'b0;
      win_row      <= '0;
      win_col      <= '0;
      done         <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      window_valid <= 1'b0;
      done         <= 1'b0;
      case (state)
        IDLE: begin
          if (start) state <= RUN;
        end
        RUN: begin
          if (accept) begin
            if (row >= ROW_K && col >= COL_K) begin
              window_valid <= 1'b1;
              win_row      <= row - ROW_K;
              win_col      <= col - COL_K;
            end
            if (col == COL_LAST) begin
              col <= '0;
              if (row == ROW_LAST) begin
                row   <= '0;
                state <= IDLE;
                done  <= 1'b1;
              end else begin
                row <= row + RW'(1);
              end
            end else begin
              col <= col + CW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_window_controller.sv
// Scoreboard bench for conv_window_controller on a 4x4 image with a 3x3 kernel.
// Driver pushes hand-computed window expectations; a negedge monitor pops and compares.
module tb_conv_window_controller;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int K  = 3;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          shift_enable;
  logic [DW-1:0] shift_data;
  logic          window_valid;
  logic [1:0]    win_row;
  logic [1:0]    win_col;
  logic          busy;
  logic          done;

  conv_window_controller #(
    .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .KERNEL_SIZE(K), .DATA_WIDTH(DW)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .shift_enable(shift_enable), .shift_data(shift_data),
    .window_valid(window_valid), .win_row(win_row), .win_col(win_col),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  typedef struct {
    int row;
    int col;
    bit last;
  } win_t;

  win_t exp_q[$];
  int   checks    = 0;
  int   failures  = 0;
  int   win_total = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every flagged window must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (window_valid) begin
      win_total++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_window: got (%0d,%0d) expected none at %0t",
                 win_row, win_col, $time);
      end else begin
        win_t e;
        e = exp_q.pop_front();
        check("win_row", win_row, e.row);
        check("win_col", win_col, e.col);
        check("win_done", done, e.last);
      end
    end else if (done) begin
      checks++;
      failures++;
      $display("FAIL done_without_window: got done=1 window_valid=0 expected window_valid=1 at %0t",
               $time);
    end
  end

  // Hand-computed windows for the 4x4 / 3x3 case: pixels 11,12,15,16 complete windows.
  task automatic push_expected(input int p);
    win_t e;
    case (p)
      11: begin e.row = 0; e.col = 0; e.last = 1'b0; exp_q.push_back(e); end
      12: begin e.row = 0; e.col = 1; e.last = 1'b0; exp_q.push_back(e); end
      15: begin e.row = 1; e.col = 0; e.last = 1'b0; exp_q.push_back(e); end
      16: begin e.row = 1; e.col = 1; e.last = 1'b1; exp_q.push_back(e); end
      default: ;
    endcase
  endtask

  // Called at a negedge; returns at the negedge after the pixel's accepting edge.
  task automatic drive_pixel(input int p, input bit poke_start);
    in_valid = 1'b1;
    in_data  = DW'(p);
    start    = poke_start;
    push_expected(p);
    #1;
    check("in_ready_run", in_ready, 1);
    check("shift_enable_on", shift_enable, 1);
    check("shift_data", shift_data, p);
    @(negedge clock);
    in_valid = 1'b0;
    start    = 1'b0;
    if (p == 9 || p == 10) check("row_wrap_no_window", window_valid, 0);
    if (p == 16) begin
      check("done_pulse", done, 1);
      check("busy_after_done", busy, 0);
    end
  endtask

  task automatic stall_cycle();
    in_valid = 1'b0;
    in_data  = 32'hdead_beef;
    #1;
    check("shift_enable_stall", shift_enable, 0);
    @(negedge clock);
  endtask

  task automatic run_frame(input bit need_start, input bit stall, input int poke_at,
                           input int stop_after);
    int base;
    base = win_total;
    if (need_start) begin
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      check("in_ready_after_start", in_ready, 1);
    end
    for (int p = 1; p <= stop_after; p++) begin
      if (stall) stall_cycle();
      drive_pixel(p, p == poke_at);
    end
    if (stop_after == 16) begin
      #2;
      check("windows_per_frame", win_total - base, 4);
      check("queue_drained", exp_q.size(), 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (2) @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_window_valid", window_valid, 0);
    check("rst_done", done, 0);
    check("rst_win_row", win_row, 0);
    check("rst_win_col", win_col, 0);
    reset = 1'b0;

    // Idle: valid data without start must not be accepted.
    in_valid = 1'b1;
    in_data  = 32'd99;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("idle_in_ready", in_ready, 0);
      check("idle_shift_enable", shift_enable, 0);
      check("idle_busy", busy, 0);
    end
    in_valid = 1'b0;

    run_frame(1'b1, 1'b0, 0, 16);   // basic frame
    @(negedge clock);
    check("idle_after_frame", busy, 0);
    run_frame(1'b1, 1'b1, 0, 16);   // stalls every other cycle
    @(negedge clock);
    run_frame(1'b1, 1'b0, 5, 16);   // start poked mid-frame is ignored

    // Start issued in the done cycle launches the next frame immediately.
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("in_ready_after_done_start", in_ready, 1);
    run_frame(1'b0, 1'b0, 0, 7);

    // Reset after 7 accepts.
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_window_valid", window_valid, 0);
    check("midrst_done", done, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_queue", exp_q.size(), 0);
    run_frame(1'b1, 1'b0, 0, 16);

    repeat (3) @(negedge clock);
    check("final_busy", busy, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
